// File: rtl/alu_sra_reg.sv
`default_nettype none
// ============================================================================
// Module      : alu_sra_reg
// Description : Registered 32-bit arithmetic right shifter (five-level barrel
//               shifter, stages 16/8/4/2/1) with a valid flag.
//               Define ALU_SRA_INREG_EN to register the inputs (latency 2).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sra_reg (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] data_operandA,
    input  logic [4:0]  ctrl_shiftamt,
    output logic [31:0] data_result,
    output logic        out_valid
);

    logic        w_sh_valid;
    logic [31:0] w_sh_operand;
    logic [4:0]  w_sh_amt;

`ifdef ALU_SRA_INREG_EN
    logic        r_in_valid;
    logic [31:0] r_operand;
    logic [4:0]  r_amt;

    // Operands only load when qualified, so unqualified X never enters the shifter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_in_valid <= 1'b0;
            r_operand  <= '0;
            r_amt      <= '0;
        end else begin
            r_in_valid <= in_valid;
            if (in_valid) begin
                r_operand <= data_operandA;
                r_amt     <= ctrl_shiftamt;
            end
        end
    end

    assign w_sh_valid   = r_in_valid;
    assign w_sh_operand = r_operand;
    assign w_sh_amt     = r_amt;
`else
    assign w_sh_valid   = in_valid;
    assign w_sh_operand = data_operandA;
    assign w_sh_amt     = ctrl_shiftamt;
`endif

    logic [31:0] w_stage [0:5];

    assign w_stage[0] = w_sh_operand;

    generate
        for (genvar s = 0; s < 5; s++) begin : g_stage
            localparam int C_LVL  = 4 - s;
            localparam int C_DIST = 1 << C_LVL;
            assign w_stage[s+1] = w_sh_amt[C_LVL]
                ? {{C_DIST{w_sh_operand[31]}}, w_stage[s][31:C_DIST]}
                : w_stage[s];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            data_result <= '0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= w_sh_valid;
            if (w_sh_valid) begin
                data_result <= w_stage[5];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sra_reg.sv
`default_nettype none
// Directed testbench for alu_sra_reg: reset, sign fill, positive operands,
// exhaustive sweep, valid gaps and mid-stream reset.
module tb_alu_sra_reg;

`ifdef ALU_SRA_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [31:0] data_operandA;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_result;
    logic        out_valid;

    int errors;
    int checks;

    logic [32:0] hist [$];
    logic [31:0] m_data;

    alu_sra_reg dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .data_operandA (data_operandA),
        .ctrl_shiftamt (ctrl_shiftamt),
        .data_result   (data_result),
        .out_valid     (out_valid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one cycle of inputs, advance past the edge, and return what the
    // outputs must show now. res is the caller's expected shift result.
    task automatic tick(input logic rst, input logic v, input logic [31:0] a,
                        input logic [4:0] s, input logic [31:0] res,
                        output logic ev, output logic [31:0] ed);
        logic [32:0] ent;
        reset         = rst;
        in_valid      = v;
        data_operandA = a;
        ctrl_shiftamt = s;
        @(posedge clock);
        #1;
        if (rst) begin
            hist.delete();
            for (int i = 0; i < LAT - 1; i++) hist.push_back(33'd0);
            m_data = 32'd0;
            ev     = 1'b0;
            ed     = 32'd0;
        end else begin
            hist.push_back({v, res});
            ent = hist.pop_front();
            if (ent[32]) m_data = ent[31:0];
            ev = ent[32];
            ed = m_data;
        end
    endtask

    task automatic test_reset;
        logic ev;
        logic [31:0] ed;
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF, ev, ed);
            checks++;
            if (out_valid !== 1'b0 || data_result !== 32'h0000_0000) begin
                errors++;
                $display("FAIL reset_hold%0d: valid=%b data=%h required valid=0 data=00000000",
                         i, out_valid, data_result);
            end
        end
        tick(1'b0, 1'b1, 32'h0000_00F0, 5'd4, 32'h0000_000F, ev, ed);
        for (int i = 0; i < LAT + 1; i++) begin
            checks++;
            if (out_valid !== ev || data_result !== ed) begin
                errors++;
                $display("FAIL reset_release%0d: valid=%b data=%h required valid=%b data=%h",
                         i, out_valid, data_result, ev, ed);
            end
            tick(1'b0, 1'b0, 32'hx, 5'hx, 32'h0, ev, ed);
        end
    endtask

    task automatic test_sign_fill;
        logic ev;
        logic [31:0] ed;
        logic [31:0] ops [0:5];
        logic [4:0]  amts [0:5];
        logic [31:0] exps [0:5];
        ops[0] = 32'h8000_0000; amts[0] = 5'd31; exps[0] = 32'hFFFF_FFFF;
        ops[1] = 32'hF000_0000; amts[1] = 5'd4;  exps[1] = 32'hFF00_0000;
        ops[2] = 32'h8000_0000; amts[2] = 5'd1;  exps[2] = 32'hC000_0000;
        ops[3] = 32'h7FFF_FFFF; amts[3] = 5'd31; exps[3] = 32'h0000_0000;
        ops[4] = 32'h0000_00F0; amts[4] = 5'd4;  exps[4] = 32'h0000_000F;
        ops[5] = 32'h1234_5678; amts[5] = 5'd0;  exps[5] = 32'h1234_5678;
        for (int i = 0; i < 6 + LAT; i++) begin
            if (i < 6) tick(1'b0, 1'b1, ops[i], amts[i], exps[i], ev, ed);
            else       tick(1'b0, 1'b0, 32'hx, 5'hx, 32'h0, ev, ed);
            checks++;
            if (out_valid !== ev || data_result !== ed) begin
                errors++;
                $display("FAIL directed%0d: valid=%b data=%h required valid=%b data=%h",
                         i, out_valid, data_result, ev, ed);
            end
        end
    endtask

    task automatic test_sweep;
        logic ev;
        logic [31:0] ed;
        logic [31:0] a;
        logic [31:0] res;
        int bad;
        bad = 0;
        for (int n = 0; n < 512; n++) begin
            a = {n[8], 23'd0, n[7:0]};
            for (int s = 0; s < 32; s++) begin
                res = $unsigned($signed(a) >>> s);
                tick(1'b0, 1'b1, a, s[4:0], res, ev, ed);
                checks++;
                if (out_valid !== ev || data_result !== ed) begin
                    errors++;
                    if (bad < 10)
                        $display("FAIL sweep op=%h sh=%0d: valid=%b data=%h required valid=%b data=%h",
                                 a, s, out_valid, data_result, ev, ed);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_gaps;
        logic ev;
        logic [31:0] ed;
        logic [4:0] pat;
        pat = 5'b10110;
        for (int i = 0; i < 5 + LAT; i++) begin
            if (i < 5 && pat[4 - i])
                tick(1'b0, 1'b1, 32'h8765_4321 + i, 5'(i * 3),
                     $unsigned($signed(32'h8765_4321 + i) >>> (i * 3)), ev, ed);
            else
                tick(1'b0, 1'b0, 32'hx, 5'hx, 32'h0, ev, ed);
            checks++;
            if (out_valid !== ev || data_result !== ed) begin
                errors++;
                $display("FAIL gaps%0d: valid=%b data=%h required valid=%b data=%h",
                         i, out_valid, data_result, ev, ed);
            end
        end
    endtask

    task automatic test_midstream_reset;
        logic ev;
        logic [31:0] ed;
        tick(1'b0, 1'b1, 32'h8000_0000, 5'd2, 32'hE000_0000, ev, ed);
        tick(1'b0, 1'b1, 32'h4000_0000, 5'd2, 32'h1000_0000, ev, ed);
        tick(1'b1, 1'b1, 32'hFFFF_0000, 5'd8, 32'hFFFF_FF00, ev, ed);
        checks++;
        if (out_valid !== 1'b0 || data_result !== 32'h0000_0000) begin
            errors++;
            $display("FAIL midstream_reset: valid=%b data=%h required valid=0 data=00000000",
                     out_valid, data_result);
        end
        tick(1'b0, 1'b1, 32'hAAAA_0000, 5'd16, 32'hFFFF_AAAA, ev, ed);
        for (int i = 0; i < LAT + 1; i++) begin
            checks++;
            if (out_valid !== ev || data_result !== ed) begin
                errors++;
                $display("FAIL after_reset%0d: valid=%b data=%h required valid=%b data=%h",
                         i, out_valid, data_result, ev, ed);
            end
            tick(1'b0, 1'b0, 32'hx, 5'hx, 32'h0, ev, ed);
        end
        checks++;
        if (data_result !== 32'hFFFF_AAAA) begin
            errors++;
            $display("FAIL sra16_result: data=%h required data=ffffaaaa", data_result);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        m_data        = 32'd0;
        reset         = 1'b1;
        in_valid      = 1'b0;
        data_operandA = 32'd0;
        ctrl_shiftamt = 5'd0;
        test_reset();
        test_sign_fill();
        test_sweep();
        test_gaps();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
